multicycle_control: RTL and testbench

- Multicycle successor to the single-cycle MIPS control decoder.
- A Moore-style FSM sequences each instruction through fetch, decode, execute, memory and writeback, one step per cycle.
- Stalls on a memory-ready handshake, bounds stalls with a timeout, traps illegal opcodes, and counts retired instructions.
- Sits between the instruction register (IR) and the shared datapath: PC, IR, register file, ALU and unified memory.

---
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready with an optional timeout, traps illegal opcodes, counts retirements.
module multicycle_control #(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_src,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               sign_zero,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               shamt_sel,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [CNT_W-1:0]   retired,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB = 4'd5,  MEMWR  = 4'd6,  REXEC  = 4'd7,
    RWB    = 4'd8,  IEXEC = 4'd9,  IWB    = 4'd10, BRANCH = 4'd11,
    JUMP   = 4'd12, TRAP  = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       sign_zero;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       shamt_sel;
    logic       trap;
  } ctrl_t;

  localparam logic [OP_W-1:0]    OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0]    OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0]    OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0]    OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0]    OP_BGT   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0]    OP_XORI  = OP_W'(6'b001110);
  localparam logic [OP_W-1:0]    OP_J     = OP_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] FN_SLL   = FUNCT_W'(6'h00);
  localparam logic [FUNCT_W-1:0] FN_SRL   = FUNCT_W'(6'h02);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t            state, next;
  ctrl_t             ctrl;
  logic [1:0]        cause_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              stall, timeout_hit, retire, fetch_hs;

  // Moore control word for a given state; opcode/funct are stable from DECODE on.
  function automatic ctrl_t decode(input state_t s, input logic [OP_W-1:0] op,
                                   input logic [FUNCT_W-1:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      REXEC:  begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        c.shamt_sel = (fn == FN_SLL) || (fn == FN_SRL);
      end
      RWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      IEXEC:  begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; c.sign_zero = 1'b1;
      end
      IWB:    c.reg_write = 1'b1;
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.branch_src    = (op == OP_BGT);
      end
      JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      TRAP:   c.trap = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  assign stall       = (state == FETCH || state == MEMRD || state == MEMWR) && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && stall && (wait_cnt == WAIT_LAST);

  always_comb begin
    next       = state;
    cause_next = trap_cause;
    case (state)
      IDLE:   next = FETCH;
      FETCH:  if (mem_ready) next = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:       next = REXEC;
          OP_LW, OP_SW:   next = MEMADR;
          OP_BEQ, OP_BGT: next = BRANCH;
          OP_XORI:        next = IEXEC;
          OP_J:           next = JUMP;
          default: begin
            next       = TRAP;
            cause_next = 2'b01;
          end
        endcase
      end
      MEMADR: next = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) next = MEMWB;
      MEMWR:  if (mem_ready) next = FETCH;
      REXEC:  next = RWB;
      IEXEC:  next = IWB;
      MEMWB, RWB, IWB, BRANCH, JUMP: next = FETCH;
      TRAP:   next = TRAP;
      default: next = IDLE;
    endcase
    if (timeout_hit) begin
      next       = TRAP;
      cause_next = 2'b10;
    end
  end

  assign retire = (next == FETCH) &&
                  (state == MEMWB || state == MEMWR || state == RWB ||
                   state == IWB   || state == BRANCH || state == JUMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ctrl       <= '0;
      trap_cause <= 2'b00;
      retired    <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= next;
      ctrl       <= decode(next, opcode, funct);
      trap_cause <= cause_next;
      if (retire) retired <= retired + CNT_W'(1);
      wait_cnt   <= (stall && next == state) ? wait_cnt + WAIT_W'(1) : '0;
    end
  end

  // IR/PC load in FETCH follow the handshake combinationally.
  assign fetch_hs      = (state == FETCH) && mem_ready;
  assign ir_write      = fetch_hs;
  assign pc_write      = ctrl.pc_write | fetch_hs;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_src    = ctrl.branch_src;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign sign_zero     = ctrl.sign_zero;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign shamt_sel     = ctrl.shamt_sel;
  assign trap          = ctrl.trap;
  assign state_o       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-cycle comparison of state, control
// word, retired count and trap cause against an instruction-sequence reference model.
module tb_multicycle_control;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, branch_src, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, sign_zero, alu_src_a, shamt_sel, trap;
  logic [1:0]  alu_src_b, alu_op, pc_source, trap_cause;
  logic [31:0] retired;
  logic [3:0]  state_o;

  multicycle_control #(.OP_W(6), .FUNCT_W(6), .CNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_src(branch_src),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .sign_zero(sign_zero), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .shamt_sel(shamt_sel), .trap(trap),
    .trap_cause(trap_cause), .retired(retired), .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [19:0] ctrl_word;
  assign ctrl_word = {pc_write, pc_write_cond, branch_src, iord, mem_read, mem_write,
                      ir_write, mem_to_reg, reg_dst, reg_write, sign_zero, alu_src_a,
                      alu_src_b, alu_op, pc_source, shamt_sel, trap};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: current step plus the remaining steps of the instruction.
  int          m_state, m_wcnt, m_cause;
  logic [31:0] m_retired;
  int          plan[$];

  task automatic model_reset();
    m_state = 0; m_wcnt = 0; m_cause = 0; m_retired = '0;
    plan.delete();
  endtask

  task automatic model_step();
    if (m_state == 15) return;
    if (m_state == 0) begin m_state = 1; return; end
    if ((m_state == 1 || m_state == 4 || m_state == 6) && !mem_ready) begin
      m_wcnt++;
      if (TO != 0 && m_wcnt == TO) begin m_state = 15; m_cause = 2; end
      return;
    end
    m_wcnt = 0;
    if (m_state == 1) m_state = 2;
    else if (m_state == 2) begin
      plan.delete();
      case (opcode)
        6'h00:        begin plan.push_back(7); plan.push_back(8); end
        6'h23:        begin plan.push_back(3); plan.push_back(4); plan.push_back(5); end
        6'h2B:        begin plan.push_back(3); plan.push_back(6); end
        6'h04, 6'h05: plan.push_back(11);
        6'h0E:        begin plan.push_back(9); plan.push_back(10); end
        6'h02:        plan.push_back(12);
        default: ;
      endcase
      if (plan.size() == 0) begin m_state = 15; m_cause = 1; end
      else m_state = plan.pop_front();
    end else if (plan.size() != 0) m_state = plan.pop_front();
    else begin
      m_state = 1;
      m_retired = m_retired + 32'd1;
    end
  endtask

  function automatic logic [19:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic rdy);
    logic pcw, pcc, bsrc, ad, mr, mw, irw, m2r, rd, rw, sz, sa, sh, tr;
    logic [1:0] sb, aop, psrc;
    {pcw, pcc, bsrc, ad, mr, mw, irw, m2r, rd, rw, sz, sa, sh, tr} = '0;
    sb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      1:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      2:  sb = 2'b11;
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin mr = 1; ad = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mw = 1; ad = 1; end
      7:  begin sa = 1; aop = 2'b10; sh = (fn == 6'h00 || fn == 6'h02); end
      8:  begin rd = 1; rw = 1; end
      9:  begin sa = 1; sb = 2'b10; aop = 2'b11; sz = 1; end
      10: rw = 1;
      11: begin sa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; bsrc = (op == 6'h05); end
      12: begin pcw = 1; psrc = 2'b10; end
      15: tr = 1;
      default: ;
    endcase
    return {pcw, pcc, bsrc, ad, mr, mw, irw, m2r, rd, rw, sz, sa, sb, aop, psrc, sh, tr};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0E, 6'h02};
  endfunction

  task automatic pick_instr(input int ill_pct);
    logic [5:0] ops [7];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0E, 6'h02};
    if ($urandom_range(0, 99) < ill_pct) begin
      opcode = 6'($urandom);
      if (is_legal(opcode)) opcode = 6'h3F;
    end else opcode = ops[$urandom_range(0, 6)];
    funct = $urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
  endtask

  task automatic check_all();
    check("state", 32'(state_o), 32'(m_state));
    check("ctrl", 32'(ctrl_word), 32'(exp_ctrl(m_state, opcode, funct, mem_ready)));
    check("retired", retired, m_retired);
    check("trap_cause", 32'(trap_cause), 32'(m_cause));
  endtask

  initial begin
    int stall_pct, ill_pct;
    rst = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    for (int ep = 0; ep < 12; ep++) begin
      stall_pct = (ep % 3 == 0) ? 0 : ((ep % 3 == 1) ? 20 : 55);
      ill_pct   = (ep == 0) ? 0 : 6;
      rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if (m_state <= 1) pick_instr(ill_pct);
        mem_ready = ($urandom_range(0, 99) >= stall_pct);
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
      end
      // Asynchronous reset in the middle of a cycle must clear everything at once.
      #2 rst = 1'b1;
      #1;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_ctrl", 32'(ctrl_word), 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_cause", 32'(trap_cause), 32'd0);
      model_reset();
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
